// File: rtl/mprj_wb_responder.sv
// mprj_wb_responder
// Wishbone classic responder for the user-project side of the management
// SoC user bus. Decodes one address window and serves a bank of
// byte-writable 32-bit scratch registers, with WAIT_CYCLES wait states
// before a registered one-cycle acknowledge.
//
// Optional build macro: WB_RESP_IRQ_EN
//   defined   : words NREGS (IRQ_SET) and NREGS+1 (IRQ_CLR) drive a 3-bit
//               pending register; user_irq_o = pending & user_irq_ena.
//   undefined : those words are unmapped and user_irq_o is 3'b000.
//
// Ports
//   core_clk      in   1   bus clock, rising edge
//   core_rstn     in   1   asynchronous active-low reset
//   wb_iena       in   1   bus enable; no new cycle accepted while low
//   wbs_cyc_i     in   1   bus cycle
//   wbs_stb_i     in   1   strobe
//   wbs_we_i      in   1   1 = write
//   wbs_sel_i     in   4   byte lane enables
//   wbs_adr_i     in   32  byte address
//   wbs_dat_i     in   32  write data
//   wbs_ack_o     out  1   acknowledge, one-cycle pulse
//   wbs_dat_o     out  32  read data, 0 outside the ack cycle
//   user_irq_ena  in   3   interrupt enables
//   user_irq_o    out  3   interrupt requests
//
// State  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a hit; blocked while the ack pulse is on the bus
// WAIT   | counting down wait states; aborts if cyc or stb drops
// ACK    | write committed / read data captured; ack driven next cycle

module mprj_wb_responder #(
    parameter logic [31:0] BASE_ADR    = 32'h3000_0000,
    parameter logic [31:0] ADR_MASK    = 32'hFFFF_0000,
    parameter int          NREGS       = 16,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        core_clk,
    input  logic        core_rstn,
    input  logic        wb_iena,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic [2:0]  user_irq_ena,
    output logic [2:0]  user_irq_o
);

    localparam int IDXW = (NREGS > 1) ? $clog2(NREGS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        commit;

    logic        lat_we;
    logic [3:0]  lat_sel;
    logic [31:0] lat_adr;
    logic [31:0] lat_dat;
    logic [31:0] rd_q;
    logic [31:0] regs [NREGS];

    logic        hit;
    logic        accept;
    logic        txn_we;
    logic [3:0]  txn_sel;
    logic [31:0] txn_adr;
    logic [31:0] txn_dat;
    logic [31:0] txn_idx;
    logic        txn_mapped;
    logic [31:0] rd_val;

    assign hit = wbs_cyc_i & wbs_stb_i & wb_iena &
                 ((wbs_adr_i & ADR_MASK) == (BASE_ADR & ADR_MASK));
    // The master still holds stb during the ack cycle; ignore it there so
    // the same transfer is not accepted twice.
    assign accept = hit & ~wbs_ack_o;

    // With zero wait states the commit happens on the accepting edge, so the
    // live bus values are used in IDLE and the latched copy otherwise.
    assign txn_we     = (state == S_IDLE) ? wbs_we_i  : lat_we;
    assign txn_sel    = (state == S_IDLE) ? wbs_sel_i : lat_sel;
    assign txn_adr    = (state == S_IDLE) ? wbs_adr_i : lat_adr;
    assign txn_dat    = (state == S_IDLE) ? wbs_dat_i : lat_dat;
    assign txn_idx    = (txn_adr & ~ADR_MASK) >> 2;
    assign txn_mapped = (txn_idx < 32'(NREGS));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    cnt_nxt = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = S_ACK;
                        commit    = 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!(wbs_cyc_i && wbs_stb_i)) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state_nxt = S_ACK;
                        commit    = 1'b1;
                    end
                end
            end
            S_ACK: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

`ifdef WB_RESP_IRQ_EN
    logic [2:0] pending;
`endif

    always_comb begin
        rd_val = 32'd0;
        if (txn_mapped) begin
            rd_val = regs[txn_idx[IDXW-1:0]];
        end
`ifdef WB_RESP_IRQ_EN
        if (txn_idx == 32'(NREGS) || txn_idx == 32'(NREGS + 1)) begin
            rd_val = {29'd0, pending};
        end
`endif
    end

    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_sel   <= 4'd0;
            lat_adr   <= 32'd0;
            lat_dat   <= 32'd0;
            rd_q      <= 32'd0;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'd0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= 32'd0;
            end
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            wbs_ack_o <= (state == S_ACK);
            wbs_dat_o <= (state == S_ACK) ? rd_q : 32'd0;
            if (state == S_IDLE && accept) begin
                lat_we  <= wbs_we_i;
                lat_sel <= wbs_sel_i;
                lat_adr <= wbs_adr_i;
                lat_dat <= wbs_dat_i;
            end
            if (commit) begin
                rd_q <= txn_we ? 32'd0 : rd_val;
                if (txn_we && txn_mapped) begin
                    for (int b = 0; b < 4; b++) begin
                        if (txn_sel[b]) begin
                            regs[txn_idx[IDXW-1:0]][8*b +: 8] <= txn_dat[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

`ifdef WB_RESP_IRQ_EN
    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            pending    <= 3'd0;
            user_irq_o <= 3'd0;
        end else begin
            user_irq_o <= pending & user_irq_ena;
            if (commit && txn_we && txn_sel[0]) begin
                if (txn_idx == 32'(NREGS)) begin
                    pending <= pending | txn_dat[2:0];
                end else if (txn_idx == 32'(NREGS + 1)) begin
                    pending <= pending & ~txn_dat[2:0];
                end
            end
        end
    end
`else
    logic unused_irq_ena;
    assign unused_irq_ena = ^user_irq_ena;
    assign user_irq_o     = 3'b000;
`endif

endmodule

// File: tb/tb_mprj_wb_responder.sv
// Three responder instances share clock and reset: index 0 has one wait
// state, index 1 three, index 2 none. A driver task issues transfers and
// pushes the expected response; the negedge monitor pops and compares.

module tb_mprj_wb_responder;

    logic        clk;
    logic        rst_n;
    logic [2:0]  irq_ena;
    logic        iena [3];
    logic        cyc  [3];
    logic        stb  [3];
    logic        we   [3];
    logic [3:0]  sel  [3];
    logic [31:0] adr  [3];
    logic [31:0] wdat [3];
    logic        ack  [3];
    logic [31:0] rdat [3];
    logic [2:0]  irq  [3];

    typedef struct {
        int          d;
        bit          rd;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc_cnt = 0;
    int   last_ack [3] = '{-10, -10, -10};
    bit   prev_ack [3] = '{0, 0, 0};

    function automatic int wc(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 3 : 0);
    endfunction

    function automatic logic [31:0] wval(input int i);
        return (32'h0101_0101 * 32'(i + 1)) ^ 32'hA500_0000;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mprj_wb_responder #(
            .WAIT_CYCLES((g == 0) ? 1 : ((g == 1) ? 3 : 0))
        ) u_dut (
            .core_clk     (clk),
            .core_rstn    (rst_n),
            .wb_iena      (iena[g]),
            .wbs_cyc_i    (cyc[g]),
            .wbs_stb_i    (stb[g]),
            .wbs_we_i     (we[g]),
            .wbs_sel_i    (sel[g]),
            .wbs_adr_i    (adr[g]),
            .wbs_dat_i    (wdat[g]),
            .wbs_ack_o    (ack[g]),
            .wbs_dat_o    (rdat[g]),
            .user_irq_ena (irq_ena),
            .user_irq_o   (irq[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            for (int d = 0; d < 3; d++) begin
                if (ack[d]) begin
                    chk("ack_width", 32'(prev_ack[d]), 32'd0);
                    chk("ack_gap", 32'((cyc_cnt - last_ack[d]) >= 2), 32'd1);
                    if (sb_q.size() == 0) begin
                        chk("unexpected_ack", 32'(d), 32'hFFFF_FFFF);
                    end else begin
                        e = sb_q.pop_front();
                        chk("ack_dut", 32'(d), 32'(e.d));
                        if (e.rd) chk("rd_data", rdat[d], e.data);
                    end
                    last_ack[d] = cyc_cnt;
                end else begin
                    chk("idle_dat_zero", rdat[d], 32'd0);
                end
                prev_ack[d] = ack[d];
            end
        end
    end

    task automatic bus(input int d, input bit w, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] dv,
                       input bit exp_ack, input logic [31:0] exp_rd);
        int n;
        bit got;
        exp_t e;
        n   = 0;
        got = 1'b0;
        if (exp_ack) begin
            e.d = d; e.rd = !w; e.data = exp_rd;
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w;
        sel[d] = s; adr[d] = a; wdat[d] = dv;
        @(posedge clk);
        for (int k = 1; k <= (exp_ack ? 40 : 32); k++) begin
            @(posedge clk); #1;
            if (ack[d]) begin
                got = 1'b1;
                n   = k;
                break;
            end
        end
        cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
        if (exp_ack) begin
            chk("ack_seen", 32'(got), 32'd1);
            if (got) chk("latency", 32'(n), 32'(1 + wc(d)));
        end else begin
            chk("no_ack", 32'(got), 32'd0);
        end
    endtask

    initial begin
        bit got;
        logic [2:0] exp_irq;
        rst_n   = 1'b0;
        irq_ena = 3'b011;
        for (int d = 0; d < 3; d++) begin
            iena[d] = 1'b1; cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
            sel[d] = 4'h0; adr[d] = 32'h0; wdat[d] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_ack", 32'(ack[d]), 32'd0);
            chk("rst_dat", rdat[d], 32'd0);
            chk("rst_irq", 32'(irq[d]), 32'd0);
        end
        rst_n = 1'b1;

        // Basic write / read, adr[1:0] ignored
        bus(0, 1, 4'hF, 32'h3000_0008, 32'hDEAD_BEEF, 1, 32'h0);
        bus(0, 0, 4'hF, 32'h3000_0008, 32'h0, 1, 32'hDEAD_BEEF);
        bus(0, 0, 4'hF, 32'h3000_000B, 32'h0, 1, 32'hDEAD_BEEF);

        // Byte lanes, sel = 0
        bus(0, 1, 4'b0101, 32'h3000_0008, 32'h1122_3344, 1, 32'h0);
        bus(0, 0, 4'hF, 32'h3000_0008, 32'h0, 1, 32'hDE22_BE44);
        bus(0, 1, 4'b0000, 32'h3000_0008, 32'hFFFF_FFFF, 1, 32'h0);
        bus(0, 0, 4'hF, 32'h3000_0008, 32'h0, 1, 32'hDE22_BE44);

        // Unmapped in window, out of window, bus disabled
        bus(0, 0, 4'hF, 32'h3000_0100, 32'h0, 1, 32'h0);
        bus(0, 1, 4'hF, 32'h3000_0100, 32'h1234_5678, 1, 32'h0);
        bus(0, 0, 4'hF, 32'h3000_0100, 32'h0, 1, 32'h0);
        bus(0, 0, 4'hF, 32'h3100_0000, 32'h0, 0, 32'h0);
        bus(0, 1, 4'hF, 32'h3100_0008, 32'h0BAD_F00D, 0, 32'h0);
        iena[0] = 1'b0;
        bus(0, 0, 4'hF, 32'h3000_0008, 32'h0, 0, 32'h0);
        bus(0, 1, 4'hF, 32'h3000_0008, 32'h0BAD_F00D, 0, 32'h0);
        iena[0] = 1'b1;
        bus(0, 0, 4'hF, 32'h3000_0008, 32'h0, 1, 32'hDE22_BE44);

        // Interrupt words
`ifdef WB_RESP_IRQ_EN
        exp_irq = 3'b011;
`else
        exp_irq = 3'b000;
`endif
        bus(0, 1, 4'hF, 32'h3000_0040, 32'h0000_0007, 1, 32'h0);
        chk("irq_after_set", 32'(irq[0]), 32'(exp_irq));
        bus(0, 0, 4'hF, 32'h3000_0040, 32'h0, 1, (exp_irq != 3'b000) ? 32'd7 : 32'd0);
        bus(0, 1, 4'hF, 32'h3000_0044, 32'h0000_0001, 1, 32'h0);
        chk("irq_after_clr", 32'(irq[0]), (exp_irq != 3'b000) ? 32'd2 : 32'd0);
        bus(0, 0, 4'hF, 32'h3000_0044, 32'h0, 1, (exp_irq != 3'b000) ? 32'd6 : 32'd0);
        chk("irq_other_dut", 32'(irq[1]), 32'd0);

        // Three wait states: aborted write leaves word 5 unchanged
        bus(1, 1, 4'hF, 32'h3000_0014, 32'h55AA_55AA, 1, 32'h0);
        @(posedge clk); #1;
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1;
        sel[1] = 4'hF; adr[1] = 32'h3000_0014; wdat[1] = 32'h1234_5678;
        @(posedge clk);
        @(posedge clk); #1;
        stb[1] = 1'b0;
        got = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (ack[1]) got = 1'b1;
        end
        cyc[1] = 1'b0; we[1] = 1'b0;
        chk("abort_no_ack", 32'(got), 32'd0);
        bus(1, 0, 4'hF, 32'h3000_0014, 32'h0, 1, 32'h55AA_55AA);

        // Reset during WAIT
        @(posedge clk); #1;
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1;
        sel[1] = 4'hF; adr[1] = 32'h3000_0014; wdat[1] = 32'h0BAD_0BAD;
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ack", 32'(ack[1]), 32'd0);
        chk("rst_mid_dat", rdat[1], 32'd0);
        cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus(1, 0, 4'hF, 32'h3000_0014, 32'h0, 1, 32'h0);
        bus(0, 0, 4'hF, 32'h3000_0008, 32'h0, 1, 32'h0);
        chk("rst_irq_clear", 32'(irq[0]), 32'd0);

        // Zero wait states: fill and read back all 16 words
        for (int i = 0; i < 16; i++)
            bus(2, 1, 4'hF, 32'h3000_0000 + 32'(4 * i), wval(i), 1, 32'h0);
        for (int i = 0; i < 16; i++)
            bus(2, 0, 4'hF, 32'h3000_0000 + 32'(4 * i), 32'h0, 1, wval(i));

        repeat (4) @(posedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
